// File: rtl/i2c_poll_sequencer.sv
// Polling sequencer for a single-byte I2C read master: periodic start, timeout
// recovery through the master's reset, valid/ready sample register and statistics.
module i2c_poll_sequencer #(
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [6:0]       address_cfg,
  output logic             rx_start,
  output logic [6:0]       rx_address,
  output logic             rx_rstn,
  input  logic             rx_finished,
  input  logic [7:0]       rx_data,
  input  logic             rx_ack,
  output logic [7:0]       out_data,
  output logic             out_nack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] nack_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_DONE, CAPTURE, HOLDOFF, RECOVER
  } state_t;

  state_t          state;
  logic [PW-1:0]   pcnt;
  logic [TW-1:0]   tcnt;
  logic            rec_second;
  logic [7:0]      cap_data;
  logic            cap_ack;
  logic            issue_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    issue_now = 1'b0;
    if (enable) begin
      if (state == IDLE)
        issue_now = 1'b1;
      else if (state == HOLDOFF && pcnt >= P_LAST)
        issue_now = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      pcnt         <= '0;
      tcnt         <= '0;
      rec_second   <= 1'b0;
      cap_data     <= '0;
      cap_ack      <= 1'b0;
      rx_start     <= 1'b0;
      rx_address   <= '0;
      rx_rstn      <= 1'b0;
      out_data     <= '0;
      out_nack     <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      sample_count <= '0;
      nack_count   <= '0;
      drop_count   <= '0;
    end else begin
      rx_start <= 1'b0;
      rx_rstn  <= 1'b1;
      if (pcnt != P_LAST) pcnt <= pcnt + 1'b1;
      if (out_ready) out_valid <= 1'b0;

      case (state)
        ISSUE: begin
          tcnt  <= tcnt + 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // finished takes priority over the timeout limit in the same cycle
          if (rx_finished) begin
            cap_data <= rx_data;
            cap_ack  <= rx_ack;
            busy     <= 1'b0;
            state    <= CAPTURE;
          end else if (tcnt == T_LAST) begin
            rx_rstn    <= 1'b0;
            rec_second <= 1'b0;
            busy       <= 1'b0;
            drop_count <= sat_inc(drop_count);
            state      <= RECOVER;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (!out_valid || out_ready) begin
            out_data     <= cap_data;
            out_nack     <= ~cap_ack;
            out_valid    <= 1'b1;
            sample_count <= sat_inc(sample_count);
          end else begin
            drop_count <= sat_inc(drop_count);
          end
          if (!cap_ack) nack_count <= sat_inc(nack_count);
          state <= HOLDOFF;
        end
        RECOVER: begin
          if (!rec_second) begin
            rx_rstn    <= 1'b0;
            rec_second <= 1'b1;
          end else begin
            state <= HOLDOFF;
          end
        end
        HOLDOFF: if (!enable) state <= IDLE;
        default: ;
      endcase

      if (issue_now) begin
        rx_start   <= 1'b1;
        rx_address <= address_cfg;
        pcnt       <= '0;
        tcnt       <= '0;
        busy       <= 1'b1;
        state      <= ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Self-checking bench for i2c_poll_sequencer: a timeline-level model compared every
// cycle, plus literal expectations taken from the directed scenarios.
module tb_i2c_poll_sequencer;
  localparam int PERIOD  = 1000;
  localparam int TIMEOUT = 200;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             enable = 1'b0;
  logic [6:0]       address_cfg = 7'h00;
  logic             rx_start;
  logic [6:0]       rx_address;
  logic             rx_rstn;
  logic             rx_finished = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ack = 1'b1;
  logic [7:0]       out_data;
  logic             out_nack;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] sample_count, nack_count, drop_count;

  i2c_poll_sequencer #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .address_cfg(address_cfg),
    .rx_start(rx_start), .rx_address(rx_address), .rx_rstn(rx_rstn),
    .rx_finished(rx_finished), .rx_data(rx_data), .rx_ack(rx_ack),
    .out_data(out_data), .out_nack(out_nack), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .sample_count(sample_count), .nack_count(nack_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Master model: answers each start after m_delay cycles unless m_never.
  int         m_delay = 40;
  bit         m_never = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic [7:0] m_inc   = 8'h00;
  logic       m_ack   = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (rstn && rx_start && !m_never) begin
        repeat (m_delay) @(posedge clk);
        #1;
        rx_finished = 1'b1;
        rx_data     = m_data;
        rx_ack      = m_ack;
        @(posedge clk);
        #1;
        rx_finished = 1'b0;
        m_data      = m_data + m_inc;
      end
    end
  end

  // Cycle index since reset release (0 = still reset or no edge yet).
  int cyc = 0;
  always @(posedge clk) begin
    if (!rstn) cyc = 0;
    else       cyc = cyc + 1;
  end

  // Timeline model: a transaction is described by its start cycle, its end cycle
  // (finish or timeout) and the first cycle it may be followed by a new start.
  int               m_s, m_end, m_hold, m_cap;
  bit               m_live, m_to;
  logic [6:0]       m_addr;
  logic [7:0]       md, cap_d;
  logic             mv, mn, cap_a;
  logic [CNT_W-1:0] m_smp, m_nck, m_drp;
  logic             ip_en, ip_rdy, ip_fin, ip_ack;
  logic [7:0]       ip_data;
  logic [6:0]       ip_addr;
  int               c, pc;
  bit               was_idle, was_hold, was_wait, e_start, load;
  int               start_q[$];
  int               fall_q[$];
  int               low_q[$];
  int               low_len;
  logic             prev_rrstn;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rstn || cyc == 0) begin
      m_live = 0; m_to = 0; m_s = -100; m_end = -100; m_hold = -1; m_cap = -100;
      m_addr = '0; md = '0; mn = 0; mv = 0; cap_d = '0; cap_a = 1;
      m_smp = '0; m_nck = '0; m_drp = '0;
      low_len = 0; prev_rrstn = 1'b1;
      check("reset rx_start", rx_start, 0);
      check("reset rx_rstn", rx_rstn, 0);
      check("reset busy", busy, 0);
      check("reset out_valid", out_valid, 0);
      check("reset out_data", {out_nack, out_data, 1'b0, rx_address}, 0);
      check("reset counters", {sample_count, nack_count, drop_count}, 0);
    end else begin
      c  = cyc;
      pc = c - 1;
      load = 0;
      if (pc == m_cap) begin
        load = !mv || ip_rdy;
        if (load) m_smp = bump(m_smp);
        else      m_drp = bump(m_drp);
        if (!cap_a) m_nck = bump(m_nck);
      end
      if (load) begin
        mv = 1; md = cap_d; mn = !cap_a;
      end else if (mv && ip_rdy) begin
        mv = 0;
      end

      was_idle = !m_live;
      was_hold = m_live && m_hold >= 0 && pc >= m_hold;
      was_wait = m_live && m_end < 0 && pc > m_s;
      e_start  = 0;
      if (was_idle && ip_en) e_start = 1;
      if (was_hold) begin
        if (!ip_en) m_live = 0;
        else if (pc - m_s >= PERIOD - 1) e_start = 1;
      end
      if (was_wait) begin
        if (ip_fin) begin
          m_end = pc; m_cap = c; cap_d = ip_data; cap_a = ip_ack; m_hold = c + 1;
        end else if (pc - m_s == TIMEOUT - 1) begin
          m_end = pc; m_to = 1; m_drp = bump(m_drp); m_hold = c + 2;
        end
      end
      if (e_start) begin
        m_live = 1; m_s = c; m_end = -1; m_hold = -1; m_to = 0; m_addr = ip_addr;
      end

      check("rx_start", rx_start, e_start);
      check("busy", busy, m_live && m_end < 0);
      check("rx_rstn", rx_rstn, !(m_to && (c == m_end + 1 || c == m_end + 2)));
      check("rx_address", rx_address, m_addr);
      check("out_valid", out_valid, mv);
      check("out_data", out_data, md);
      check("out_nack", out_nack, mn);
      check("sample_count", sample_count, m_smp);
      check("nack_count", nack_count, m_nck);
      check("drop_count", drop_count, m_drp);

      if (rx_start) start_q.push_back(c);
      if (prev_rrstn && !rx_rstn) fall_q.push_back(c);
      if (!rx_rstn) low_len++;
      else if (low_len > 0) begin
        low_q.push_back(low_len);
        low_len = 0;
      end
      prev_rrstn = rx_rstn;
    end
    ip_en = enable; ip_rdy = out_ready; ip_fin = rx_finished;
    ip_ack = rx_ack; ip_data = rx_data; ip_addr = address_cfg;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0; enable = 1'b0; out_ready = 1'b1; m_never = 1'b0; m_inc = 8'h00;
    start_q.delete(); fall_q.delete(); low_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (start_q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("start seen within budget", start_q.size() >= n, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Periodic polling with ACKed reads
    do_reset();
    address_cfg = 7'h48; m_delay = 40; m_data = 8'hA5; m_ack = 1'b1; out_ready = 1'b1;
    enable = 1'b1;
    wait_starts(3, 2200);
    tick(60);
    check("poll sample_count", sample_count, 3);
    check("poll out_data", out_data, 8'hA5);
    check("poll out_nack", out_nack, 0);
    check("poll rx_address", rx_address, 7'h48);
    check("poll spacing 1", start_q[1] - start_q[0], PERIOD);
    check("poll spacing 2", start_q[2] - start_q[1], PERIOD);

    // NACKed read still delivers the byte
    do_reset();
    m_data = 8'hFF; m_ack = 1'b0; out_ready = 1'b0; enable = 1'b1;
    wait_starts(1, 50);
    enable = 1'b0;
    tick(60);
    check("nack out_valid", out_valid, 1);
    check("nack out_nack", out_nack, 1);
    check("nack out_data", out_data, 8'hFF);
    check("nack nack_count", nack_count, 1);
    check("nack sample_count", sample_count, 1);

    // Full output register drops new samples
    do_reset();
    m_data = 8'h11; m_inc = 8'h11; m_ack = 1'b1; out_ready = 1'b0; enable = 1'b1;
    wait_starts(3, 2200);
    tick(60);
    enable = 1'b0;
    check("full out_data", out_data, 8'h11);
    check("full drop_count", drop_count, 2);
    check("full sample_count", sample_count, 1);
    check("full out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick(1);
    check("handshake clears valid", out_valid, 0);
    tick(1);
    check("handshake valid stays low", out_valid, 0);

    // Timeout and master recovery
    do_reset();
    m_never = 1'b1; enable = 1'b1;
    wait_starts(2, 1200);
    check("timeout spacing", start_q[1] - start_q[0], PERIOD);
    check("timeout rx_rstn fall", fall_q[0] - start_q[0], TIMEOUT);
    check("timeout rx_rstn low cycles", low_q[0], 2);
    check("timeout drop_count", drop_count, 1);
    enable = 1'b0;
    tick(300);
    check("timeout drop_count 2", drop_count, 2);
    check("timeout busy", busy, 0);

    // Disable mid-transaction
    do_reset();
    m_delay = 40; m_data = 8'h5A; m_ack = 1'b1; out_ready = 1'b1; enable = 1'b1;
    wait_starts(1, 50);
    tick(9);
    enable = 1'b0;
    tick(1100);
    check("disable start count", start_q.size(), 1);
    check("disable sample_count", sample_count, 1);
    check("disable out_data", out_data, 8'h5A);
    check("disable busy", busy, 0);

    // Asynchronous reset during WAIT_DONE
    do_reset();
    m_never = 1'b1; enable = 1'b1;
    wait_starts(1, 50);
    tick(20);
    check("pre-reset busy", busy, 1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async busy", busy, 0);
    check("async rx_rstn", rx_rstn, 0);
    check("async rx_address", rx_address, 0);
    check("async drop_count", drop_count, 0);
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    rstn = 1'b1;
    #1;
    check("release rx_rstn before edge", rx_rstn, 0);
    tick(1);
    check("release rx_rstn after edge", rx_rstn, 1);
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
